decrypt_message: RTL

- RC4 keystream-generation and decryption stage. It reads the S array left in s_mem by the key-scheduling block (swap_memory) and continues to swap S in place.
- It reads MSG_LENGTH encrypted bytes from the message ROM and writes the decrypted bytes to the result RAM.
- It sits after swap_memory in the top-level control chain and reuses the same start/done handshake.

---
 rtl/decrypt_message.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/decrypt_message.sv
// RC4 keystream generation / decryption stage.
// Continues swapping the S array left in s_mem by the key schedule, reads
// MSG_LENGTH encrypted bytes from the message ROM and writes the decrypted
// bytes to the result RAM. All memories are synchronous read; each read uses
// a SET (drive address), WAIT (hold) and GET (sample q) state.
module decrypt_message #(
    parameter int unsigned MSG_LENGTH = 32,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_flag,
    output logic              done_flag,
    output logic [ADDR_W-1:0] s_address,
    output logic [7:0]        s_data_in,
    input  logic [7:0]        s_data_out,
    output logic              s_wren,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [7:0]        rom_data_out,
    output logic [ADDR_W-1:0] ram_address,
    output logic [7:0]        ram_data_in,
    output logic              ram_wren
);

    localparam logic [7:0] K_LAST = 8'(MSG_LENGTH - 1);

    typedef enum logic [3:0] {
        IDLE,
        SET_I,
        WAIT_I,
        GET_I,
        SET_J,
        WAIT_J,
        GET_J,
        WRITE_I,
        WRITE_J,
        SET_F,
        WAIT_F,
        GET_F,
        WRITE_OUT,
        INC,
        DONE
    } state_t;

    state_t     state, next_state;
    logic [7:0] i, j, k;
    logic [7:0] si, sj, f;
    logic [7:0] rom_byte;
    logic [7:0] f_index;

    // S[i] + S[j] wraps mod 256 to form the keystream lookup address
    assign f_index = si + sj;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath registers: indices, captured S values, keystream byte, ROM byte
    always_ff @(posedge clk) begin
        if (reset) begin
            i        <= 8'd1;
            j        <= '0;
            k        <= '0;
            si       <= '0;
            sj       <= '0;
            f        <= '0;
            rom_byte <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_flag) begin
                        i <= 8'd1;
                        j <= '0;
                        k <= '0;
                    end
                end
                GET_I: begin
                    si <= s_data_out;
                    j  <= j + s_data_out;
                end
                GET_J: begin
                    sj <= s_data_out;
                end
                GET_F: begin
                    f        <= s_data_out;
                    rom_byte <= rom_data_out;
                end
                INC: begin
                    if (k != K_LAST) begin
                        k <= k + 8'd1;
                        i <= i + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state logic: fixed 13-state sequence per message byte
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (start_flag) next_state = SET_I;
            SET_I:     next_state = WAIT_I;
            WAIT_I:    next_state = GET_I;
            GET_I:     next_state = SET_J;
            SET_J:     next_state = WAIT_J;
            WAIT_J:    next_state = GET_J;
            GET_J:     next_state = WRITE_I;
            WRITE_I:   next_state = WRITE_J;
            WRITE_J:   next_state = SET_F;
            SET_F:     next_state = WAIT_F;
            WAIT_F:    next_state = GET_F;
            GET_F:     next_state = WRITE_OUT;
            WRITE_OUT: next_state = INC;
            INC:       next_state = (k == K_LAST) ? DONE : SET_I;
            DONE:      if (!start_flag) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Moore outputs decoded from state and registers only
    always_comb begin
        done_flag   = 1'b0;
        s_address   = '0;
        s_data_in   = '0;
        s_wren      = 1'b0;
        rom_address = '0;
        ram_address = '0;
        ram_data_in = '0;
        ram_wren    = 1'b0;
        case (state)
            SET_I, WAIT_I: begin
                s_address = ADDR_W'(i);
            end
            SET_J, WAIT_J: begin
                s_address = ADDR_W'(j);
            end
            WRITE_I: begin
                s_address = ADDR_W'(i);
                s_data_in = sj;
                s_wren    = 1'b1;
            end
            WRITE_J: begin
                s_address = ADDR_W'(j);
                s_data_in = si;
                s_wren    = 1'b1;
            end
            SET_F, WAIT_F: begin
                s_address   = ADDR_W'(f_index);
                rom_address = ADDR_W'(k);
            end
            WRITE_OUT: begin
                ram_address = ADDR_W'(k);
                ram_data_in = f ^ rom_byte;
                ram_wren    = 1'b1;
            end
            DONE: begin
                done_flag = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
